// File: rtl/stage2_window_gen_pkg.sv
// Shared constants for the stage-2 sliding-window path.
// KX/KY       : convolution window size.
// DATA_BW     : stage-2 convolution input pixel width (signed, passed through).
// IMG_W/IMG_H : stage-2 feature-map dimensions.
// win_idx()   : flat element index of window element (y,x) in the packed bus.
package stage2_window_gen_pkg;

  localparam int KX      = 5;
  localparam int KY      = 5;
  localparam int DATA_BW = 20;
  localparam int IMG_W   = 12;
  localparam int IMG_H   = 12;

  localparam int FMAP_BW = KX * KY * DATA_BW;

  // Element (y,x) of the packed window sits at bits [win_idx(y,x)*DATA_BW +: DATA_BW].
  function automatic int win_idx(input int y, input int x);
    return y * KX + x;
  endfunction

endpackage

// File: rtl/stage2_window_gen_if.sv
// Pixel-in / window-out bus of the stage-2 window generator.
// master : pixel source (drives i_in_*) that also observes the window outputs.
// slave  : the window generator (consumes i_in_*, drives o_*).
// Signals: i_in_valid/i_in_pixel  raster-order pixel strobe, no backpressure;
//          o_ot_valid/o_ot_fmap   packed KXxKY window strobe;
//          o_frame_done           pulse with the last window of a frame.
interface stage2_window_gen_if
  import stage2_window_gen_pkg::*;
;
  logic                      i_in_valid;
  logic signed [DATA_BW-1:0] i_in_pixel;
  logic                      o_ot_valid;
  logic [FMAP_BW-1:0]        o_ot_fmap;
  logic                      o_frame_done;

  modport master (
    output i_in_valid, i_in_pixel,
    input  o_ot_valid, o_ot_fmap, o_frame_done
  );

  modport slave (
    input  i_in_valid, i_in_pixel,
    output o_ot_valid, o_ot_fmap, o_frame_done
  );

endinterface

// File: rtl/stage2_line_buffer.sv
// Row buffer for the window generator: a shift chain of ROWS*IMG_W pixels
// advanced only on i_shift. Before a shift, tap k (o_taps[k-1]) holds the
// pixel at the same column, k rows above the pixel on i_data.
// Ports: clk, reset (async, active-high), i_shift, i_data, o_taps[ROWS].
module stage2_line_buffer #(
  parameter int IMG_W   = 12,
  parameter int ROWS    = 4,
  parameter int DATA_BW = 20
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_shift,
  input  logic [DATA_BW-1:0]            i_data,
  output logic [ROWS-1:0][DATA_BW-1:0]  o_taps
);

  localparam int DEPTH = ROWS * IMG_W;

  // mem[0] is the most recently accepted pixel, mem[j] the one j+1 pixels older.
  logic [DATA_BW-1:0] mem [DEPTH];

  // NOTE: the buffer is cleared on reset so a fresh frame never sees old data;
  // a reset memory cannot map to block RAM, acceptable at this small depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_shift) begin
      // NOTE: non-blocking so every stage reads its neighbour's pre-edge value.
      mem[0] <= i_data;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  // The pixel k rows above is k*IMG_W positions older than the incoming one.
  for (genvar k = 0; k < ROWS; k++) begin : g_tap
    assign o_taps[k] = mem[(k + 1) * IMG_W - 1];
  end

endmodule

// File: rtl/stage2_window_gen.sv
// Streaming KXxKY sliding-window generator (stride 1, no padding) feeding the
// stage-2 convolution kernel. Pixels arrive in raster order on bus.i_in_*; one
// packed window is emitted one clock after each pixel whose position completes
// a full window (row >= KY-1, col >= KX-1).
// Ports: clk, reset (async, active-high), bus (stage2_window_gen_if.slave).
module stage2_window_gen
  import stage2_window_gen_pkg::*;
#(
  parameter int IMG_W = stage2_window_gen_pkg::IMG_W,
  parameter int IMG_H = stage2_window_gen_pkg::IMG_H
) (
  input  logic                 clk,
  input  logic                 reset,
  stage2_window_gen_if.slave   bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [KY-2:0][DATA_BW-1:0] taps;

  // win[y][x]: y=0 top (oldest) row, x=0 leftmost (oldest) column.
  logic [DATA_BW-1:0] win      [KY][KX];
  logic [DATA_BW-1:0] win_next [KY][KX];
  logic [FMAP_BW-1:0] fmap_next;

  logic emit;
  logic last_px;

  stage2_line_buffer #(
    .IMG_W   (IMG_W),
    .ROWS    (KY - 1),
    .DATA_BW (DATA_BW)
  ) u_line_buffer (
    .clk     (clk),
    .reset   (reset),
    .i_shift (bus.i_in_valid),
    .i_data  (bus.i_in_pixel),
    .o_taps  (taps)
  );

  // Windows that would straddle a row boundary (col < KX-1) are suppressed.
  assign emit    = bus.i_in_valid && (row >= RW'(KY - 1)) && (col >= CW'(KX - 1));
  assign last_px = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  // Window after the incoming pixel's column has been shifted in; it is both
  // the next window state and, when emitting, the value driven to the kernel.
  always_comb begin
    // NOTE: start from the current value so every path assigns; no latch.
    win_next = win;
    for (int y = 0; y < KY; y++) begin
      for (int x = 0; x < KX - 1; x++) win_next[y][x] = win[y][x+1];
    end
    win_next[KY-1][KX-1] = bus.i_in_pixel;
    for (int k = 1; k < KY; k++) win_next[KY-1-k][KX-1] = taps[k-1];

    fmap_next = '0;
    for (int y = 0; y < KY; y++) begin
      for (int x = 0; x < KX; x++) begin
        fmap_next[win_idx(y, x)*DATA_BW +: DATA_BW] = win_next[y][x];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col              <= '0;
      row              <= '0;
      bus.o_ot_valid   <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_ot_fmap    <= '0;
      for (int y = 0; y < KY; y++) begin
        for (int x = 0; x < KX; x++) win[y][x] <= '0;
      end
    end else begin
      bus.o_ot_valid   <= emit;
      bus.o_frame_done <= emit && last_px;
      if (bus.i_in_valid) begin
        win <= win_next;
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      // The output bus holds the last emitted window between strobes.
      if (emit) bus.o_ot_fmap <= fmap_next;
    end
  end

endmodule
